// File: rtl/id_ex_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_register: ID/EX pipeline register with stall, flush and bubbles.    |
// | Optional macro IDEX_FWD_SRC_EN registers rn/rm for forwarding.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_ex_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [63:0] id_pc,
  input  logic [63:0] id_rd1,
  input  logic [63:0] id_rd2,
  input  logic [63:0] id_imm_zext,
  input  logic [63:0] id_imm_sext,
  input  logic        id_imm_is_zext,
  input  logic [2:0]  id_alu_op,
  input  logic        id_alu_src,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic        id_set_flags,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  output logic        ex_valid,
  output logic [63:0] ex_pc,
  output logic [63:0] ex_rd1,
  output logic [63:0] ex_rd2,
  output logic [63:0] ex_imm,
  output logic [2:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_set_flags,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rn,
  output logic [4:0]  ex_rm
);

  localparam logic [0:0] S_BUBBLE = 1'b0;
  localparam logic [0:0] S_VALID  = 1'b1;
  localparam logic [4:0] XZR      = 5'd31;

  logic [0:0] state_q, state_d;
  logic       load_bubble, load_instr;

  logic [63:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        alu_src_q, alu_src_d, mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d, reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d, set_flags_q, set_flags_d;
  logic [4:0]  rd_q, rd_d;

  // Flush wins over stall; an unstalled capture of an invalid slot is a bubble too.
  assign load_bubble = flush | (~stall & ~id_valid);
  assign load_instr  = ~flush & ~stall & id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_BUBBLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load_bubble)     state_d = S_BUBBLE;
    else if (load_instr) state_d = S_VALID;
  end

  always_comb begin
    pc_d         = pc_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    set_flags_d  = set_flags_q;
    rd_d         = rd_q;
    if (load_bubble) begin
      pc_d         = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      imm_d        = '0;
      alu_op_d     = '0;
      alu_src_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      set_flags_d  = 1'b0;
      rd_d         = XZR;
    end else if (load_instr) begin
      pc_d         = id_pc;
      rd1_d        = id_rd1;
      rd2_d        = id_rd2;
      imm_d        = id_imm_is_zext ? id_imm_zext : id_imm_sext;
      alu_op_d     = id_alu_op;
      alu_src_d    = id_alu_src;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      reg_write_d  = id_reg_write;
      mem_to_reg_d = id_mem_to_reg;
      set_flags_d  = id_set_flags;
      rd_d         = id_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      set_flags_q  <= 1'b0;
      rd_q         <= XZR;
    end else begin
      pc_q         <= pc_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      set_flags_q  <= set_flags_d;
      rd_q         <= rd_d;
    end
  end

  always_comb begin
    ex_valid      = (state_q == S_VALID);
    ex_pc         = pc_q;
    ex_rd1        = rd1_q;
    ex_rd2        = rd2_q;
    ex_imm        = imm_q;
    ex_alu_op     = alu_op_q;
    ex_alu_src    = alu_src_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_reg_write  = reg_write_q;
    ex_mem_to_reg = mem_to_reg_q;
    ex_set_flags  = set_flags_q;
    ex_rd         = rd_q;
  end

`ifdef IDEX_FWD_SRC_EN
  logic [4:0] rn_q, rn_d, rm_q, rm_d;

  always_comb begin
    rn_d = rn_q;
    rm_d = rm_q;
    if (load_bubble) begin
      rn_d = '0;
      rm_d = '0;
    end else if (load_instr) begin
      rn_d = id_rn;
      rm_d = id_rm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rn_q <= '0;
      rm_q <= '0;
    end else begin
      rn_q <= rn_d;
      rm_q <= rm_d;
    end
  end

  assign ex_rn = rn_q;
  assign ex_rm = rm_q;
`else
  // Source registers are not tracked in this build; report XZR.
  logic unused_src;
  assign unused_src = ^{id_rn, id_rm};
  assign ex_rn      = XZR;
  assign ex_rm      = XZR;
`endif

endmodule
`default_nettype wire
